// File: rtl/if_pc_unit_if.sv
// if_pc_unit_if -- bundle between the IF-stage PC unit and its neighbours.
//   Redirect/control inputs to the PC unit:
//     stall, jump_id, br_taken, br_target[31:0], exc_req, eret_req, epc[31:0]
//   Status outputs from the PC unit:
//     pc[31:0], pc8[31:0], fetch_adel, fetch_bd, flush_if, fetch_count[31:0]
//   modport slave  : the PC unit itself
//   modport master : whatever drives the controls and observes the PC
interface if_pc_unit_if;
  logic        stall;
  logic        jump_id;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc8;
  logic        fetch_adel;
  logic        fetch_bd;
  logic        flush_if;
  logic [31:0] fetch_count;

  modport slave (
    input  stall, jump_id, br_taken, br_target, exc_req, eret_req, epc,
    output pc, pc8, fetch_adel, fetch_bd, flush_if, fetch_count
  );

  modport master (
    output stall, jump_id, br_taken, br_target, exc_req, eret_req, epc,
    input  pc, pc8, fetch_adel, fetch_bd, flush_if, fetch_count
  );
endinterface

// File: rtl/if_pc_unit.sv
// if_pc_unit -- IF-stage program counter of the pipelined MIPS core.
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous active-high reset, beats every other request
//   bus   : if_pc_unit_if.slave carrying the redirect controls in and the
//           fetch address / fault / delay-slot / flush / counter status out
// Next-PC priority: exception entry, ERET return, stall hold, taken branch,
// sequential pc + 4. The fetch counter advances on every edge that is not a
// stall hold.
module if_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI   = 32'h0000_6ffc
) (
  input  logic          clk,
  input  logic          reset,
  if_pc_unit_if.slave   bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q + 32'd1;
    if (bus.exc_req) begin
      pc_d = EXC_ENTRY;
    end else if (bus.eret_req) begin
      pc_d = bus.epc;
    end else if (bus.stall) begin
      // ID is frozen, so a branch seen now re-asserts next cycle; drop it.
      pc_d    = pc_q;
      count_d = count_q;
    end else if (bus.br_taken) begin
      // Out-of-range targets are loaded anyway; fetch_adel reports them.
      pc_d = bus.br_target;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc8         = pc_q + 32'd8;
  assign bus.fetch_adel  = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
  // Whatever is fetched while a branch/jump sits in ID is its delay slot.
  assign bus.fetch_bd    = bus.jump_id;
  // Kill the wrong-path fetch in the same cycle as the redirect request.
  assign bus.flush_if    = bus.exc_req || bus.eret_req;
  assign bus.fetch_count = count_q;

endmodule

// File: doc/if_pc_unit.md
Name: if_pc_unit

Overview:
- IF-stage program-counter unit of the pipelined MIPS core; sits directly upstream of the instruction memory and drives its fetch address every cycle.
- Selects the next PC from these sources: sequential, ID-stage branch/jump target, exception entry, and ERET return.
- Flags instruction-fetch address errors (AdEL) and delay-slot status for CP0.
- Keeps a fetched-instruction counter for debug.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_ENTRY, 32'h0000_4180, handler entry address for exceptions and interrupts.
- TEXT_LO, 32'h0000_3000, lowest legal fetch address.
- TEXT_HI, 32'h0000_6ffc, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; takes effect on the rising edge of clk.
- stall  in  1  hazard stall from the hazard unit; holds the PC.
- jump_id  in  1  the ID-stage instruction is a branch or jump, taken or not.
- br_taken  in  1  ID-stage branch/jump resolved taken this cycle.
- br_target  in  32  redirect address for a taken branch/jump.
- exc_req  in  1  CP0 requests exception or interrupt entry.
- eret_req  in  1  ERET is committing; return to epc.
- epc  in  32  return address from CP0.
- pc  out  32  current fetch address, sent to the instruction memory.
- pc8  out  32  pc + 8, the link address carried down the pipe.
- fetch_adel  out  1  current pc is misaligned or outside [TEXT_LO, TEXT_HI].
- fetch_bd  out  1  the instruction at pc is a delay-slot instruction.
- flush_if  out  1  the instruction at pc must be replaced by a nop in IF/ID.
- fetch_count  out  32  number of PC advances since reset.

Behaviour:
- State: pc register (32 b), fetch_count register (32 b). All other outputs are combinational from state and inputs.
- Reset (synchronous): pc <= RESET_PC, fetch_count <= 0. Reset has priority over every other input, including exc_req.
- Next-PC priority, highest first:
  - exc_req: pc <= EXC_ENTRY.
  - eret_req: pc <= epc.
  - stall: pc holds.
  - br_taken: pc <= br_target.
  - otherwise: pc <= pc + 4.
- exc_req and eret_req override stall. A stalled branch is ignored, because ID is frozen and the branch re-asserts on the next cycle.
- fetch_count increments by 1 on every non-reset edge where pc changes source or advances, i.e. any edge except a stall hold. It wraps modulo 2^32.
- All address arithmetic is 32-bit unsigned; pc + 4 and pc + 8 wrap silently.
- fetch_adel = (pc[1:0] != 0) || (pc < TEXT_LO) || (pc > TEXT_HI).
  - fetch_adel does not change the PC; CP0 raises exc_req in response.
  - While fetch_adel is high, pc still reports the faulting address so CP0 can latch it as EPC.
- fetch_bd = jump_id. The instruction fetched in the same cycle a branch/jump sits in ID is its delay slot, whether or not the branch is taken.
- flush_if = exc_req || eret_req. It is asserted in the same cycle as the redirect request, killing the wrong-path fetch.
  - ERET has no delay slot.
  - A delay-slot instruction is not flushed by br_taken.
- Reset mid-stall or mid-redirect: reset wins, and the next pc is RESET_PC.
- Simultaneous exc_req and eret_req: exception entry wins, and flush_if = 1.
- A branch target outside the legal range is still loaded. The fault is reported through fetch_adel on the following cycle, not blocked.
- Latency: every redirect is visible on pc one cycle after the request edge. There is no internal buffering of requests.

Test Plan:
- Sequential fetch: reset for one cycle, then 3 free cycles -> pc = 3000, 3004, 3008, 300c; pc8 = 3014 at pc = 300c; fetch_count = 3; fetch_adel = 0.
- Branch with delay slot: at pc = 3010, drive jump_id = 1, br_taken = 1, br_target = 3040 -> fetch_bd = 1, flush_if = 0 that cycle; next pc = 3040.
- Stall interactions: stall = 1 for 2 cycles at pc = 3020 -> pc holds 3020 and fetch_count unchanged. stall = 1 with br_taken = 1 -> pc holds. stall = 1 with exc_req = 1 -> pc = 4180 and flush_if = 1.
- Exception vs ERET: exc_req = 1 and eret_req = 1 together -> pc = 4180. Later, eret_req = 1 with epc = 3124 -> flush_if = 1, next pc = 3124.
- Fetch address error: br_target = 3002 -> next cycle pc = 3002, fetch_adel = 1. br_target = 7000 -> fetch_adel = 1. pc = 6ffc -> fetch_adel = 0.
- Reset mid-operation: reset = 1 while exc_req = 1 and pc = 3500 -> pc = 3000 and fetch_count = 0 after the edge.
